pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_control_if.sv | 24 ++
 rtl/pc_control.sv | 80 ++++++++
 tb/tb_pc_control.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_control_if.sv
// Branch-control bus: condition, offset, flags and incremented PC in;
// next PC, taken strobe and its registered copy out.
interface pc_control_if #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
);
  logic [2:0]       C;
  logic [IMM_W-1:0] I;
  logic [2:0]       F;
  logic [PC_W-1:0]  PC_in;
  logic [PC_W-1:0]  PC_out;
  logic             taken;
  logic             taken_q;

  modport master (
    output C, I, F, PC_in,
    input  PC_out, taken, taken_q
  );

  modport slave (
    input  C, I, F, PC_in,
    output PC_out, taken, taken_q
  );
endinterface

// File: rtl/pc_control.sv
// Next-PC selection for conditional branches: combinational target and
// condition decode, plus a registered copy of the taken decision.
module pc_control #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  pc_control_if.slave bus
);

  // Word offset: sign extend to full PC width first, then scale to bytes.
  function automatic logic signed [PC_W-1:0] byte_offset(input logic [IMM_W-1:0] imm);
    logic signed [PC_W-1:0] ext;
    ext = signed'({{(PC_W-IMM_W){imm[IMM_W-1]}}, imm});
    return ext <<< 1;
  endfunction

  // Generate/propagate adder; carry-out is dropped so the PC wraps.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] a,
                                             input logic [PC_W-1:0] b);
    logic [PC_W-1:0] g;
    logic [PC_W-1:0] p;
    logic [PC_W:0]   c;
    logic [PC_W-1:0] s;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    for (int k = 0; k < PC_W; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
    s = p ^ c[PC_W-1:0];
    return s;
  endfunction

  // Flags are packed {Z, V, N}; each code looks only at the flags it names.
  function automatic logic cond_taken(input logic [2:0] cc, input logic [2:0] flags);
    logic z;
    logic v;
    logic n;
    logic t;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    t = 1'b0;
    case (cc)
      3'b000:  t = ~z;
      3'b001:  t = z;
      3'b010:  t = ~z & ~n;
      3'b011:  t = n;
      3'b100:  t = z | (~z & ~n);
      3'b101:  t = n | z;
      3'b110:  t = v;
      3'b111:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic signed [PC_W-1:0] offset;
  logic [PC_W-1:0]        target;
  logic                   taken_c;

  // Combinational stage: target, decode and PC mux, independent of clk/rst.
  always_comb begin
    offset  = byte_offset(bus.I);
    target  = pc_add(bus.PC_in, offset);
    taken_c = cond_taken(bus.C, bus.F);
  end

  assign bus.taken  = taken_c;
  assign bus.PC_out = taken_c ? target : bus.PC_in;

  // Register stage: registered taken, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.taken_q <= 1'b0;
    else     bus.taken_q <= taken_c;
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed and random checks of next-PC selection and the taken register.
module tb_pc_control;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pc_control_if #(.PC_W(16), .IMM_W(9)) bus ();

  pc_control #(.PC_W(16), .IMM_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [8:0] i,
                       input logic [2:0] f, input logic [15:0] pc);
    bus.C = c; bus.I = i; bus.F = f; bus.PC_in = pc;
    #1;
  endtask

  // Independent reference using integer arithmetic.
  function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] ref_pc(input logic [2:0] c, input logic [8:0] i,
                                         input logic [2:0] f, input logic [15:0] pc);
    int off;
    int sum;
    off = (i[8]) ? (int'(i) - 512) : int'(i);
    sum = int'(pc) + off * 2;
    if (!ref_taken(c, f)) return pc;
    return 16'(sum & 32'hFFFF);
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(3'b000, 9'd4, 3'b000, 16'hFF00);
    #12;
    check("reset_taken_q", {15'd0, bus.taken_q}, 16'd0);
    check("reset_pc_valid", bus.PC_out, 16'hFF08);
    @(negedge clk); rst = 1'b0;

    // Condition 000
    drive(3'b000, 9'd4, 3'b000, 16'hFF00); check("c0_f000", bus.PC_out, 16'hFF08);
    check("c0_f000_taken", {15'd0, bus.taken}, 16'd1);
    drive(3'b000, 9'd4, 3'b100, 16'hFF00); check("c0_f100", bus.PC_out, 16'hFF00);
    check("c0_f100_taken", {15'd0, bus.taken}, 16'd0);
    drive(3'b000, 9'd4, 3'b011, 16'hFF00); check("c0_f011", bus.PC_out, 16'hFF08);

    // Sweep 001..110
    drive(3'b001, 9'd4, 3'b100, 16'hFF00); check("c1_f100", bus.PC_out, 16'hFF08);
    drive(3'b001, 9'd4, 3'b000, 16'hFF00); check("c1_f000", bus.PC_out, 16'hFF00);
    drive(3'b001, 9'd4, 3'b011, 16'hFF00); check("c1_f011", bus.PC_out, 16'hFF00);
    drive(3'b010, 9'd4, 3'b000, 16'hFF00); check("c2_f000", bus.PC_out, 16'hFF08);
    drive(3'b010, 9'd4, 3'b010, 16'hFF00); check("c2_f010", bus.PC_out, 16'hFF08);
    drive(3'b010, 9'd4, 3'b001, 16'hFF00); check("c2_f001", bus.PC_out, 16'hFF00);
    drive(3'b010, 9'd4, 3'b100, 16'hFF00); check("c2_f100", bus.PC_out, 16'hFF00);
    drive(3'b011, 9'd4, 3'b001, 16'hFF00); check("c3_f001", bus.PC_out, 16'hFF08);
    drive(3'b011, 9'd4, 3'b000, 16'hFF00); check("c3_f000", bus.PC_out, 16'hFF00);
    drive(3'b011, 9'd4, 3'b110, 16'hFF00); check("c3_f110", bus.PC_out, 16'hFF00);
    drive(3'b100, 9'd4, 3'b000, 16'hFF00); check("c4_f000", bus.PC_out, 16'hFF08);
    drive(3'b100, 9'd4, 3'b100, 16'hFF00); check("c4_f100", bus.PC_out, 16'hFF08);
    drive(3'b100, 9'd4, 3'b001, 16'hFF00); check("c4_f001", bus.PC_out, 16'hFF00);
    drive(3'b101, 9'd4, 3'b001, 16'hFF00); check("c5_f001", bus.PC_out, 16'hFF08);
    drive(3'b101, 9'd4, 3'b100, 16'hFF00); check("c5_f100", bus.PC_out, 16'hFF08);
    drive(3'b101, 9'd4, 3'b000, 16'hFF00); check("c5_f000", bus.PC_out, 16'hFF00);
    drive(3'b101, 9'd4, 3'b010, 16'hFF00); check("c5_f010", bus.PC_out, 16'hFF00);
    drive(3'b110, 9'd4, 3'b010, 16'hFF00); check("c6_f010", bus.PC_out, 16'hFF08);
    drive(3'b110, 9'd4, 3'b000, 16'hFF00); check("c6_f000", bus.PC_out, 16'hFF00);
    drive(3'b110, 9'd4, 3'b101, 16'hFF00); check("c6_f101", bus.PC_out, 16'hFF00);

    // Always, backward branch, wrap, extremes
    drive(3'b111, 9'd4, 3'b000, 16'hFF00); check("c7_f000", bus.PC_out, 16'hFF08);
    drive(3'b111, 9'd4, 3'b111, 16'hFF00); check("c7_f111", bus.PC_out, 16'hFF08);
    drive(3'b111, 9'h1FC, 3'b000, 16'h0004); check("c7_back", bus.PC_out, 16'hFFFC);
    drive(3'b111, 9'd2, 3'b000, 16'hFFFE); check("c7_wrap", bus.PC_out, 16'h0002);
    drive(3'b111, 9'h1FF, 3'b000, 16'h1000); check("c7_m2", bus.PC_out, 16'h0FFE);
    drive(3'b111, 9'h100, 3'b000, 16'h1000); check("c7_min", bus.PC_out, 16'h0E00);
    drive(3'b111, 9'h0FF, 3'b000, 16'h1000); check("c7_max", bus.PC_out, 16'h11FE);

    // Register behaviour and asynchronous reset
    @(negedge clk);
    drive(3'b111, 9'd4, 3'b000, 16'hFF00);
    @(posedge clk); #1;
    check("tq_set", {15'd0, bus.taken_q}, 16'd1);
    #2 rst = 1'b1; #1;
    check("tq_async_clr", {15'd0, bus.taken_q}, 16'd0);
    check("pc_in_reset", bus.PC_out, 16'hFF08);
    @(posedge clk); #1;
    check("tq_held_in_reset", {15'd0, bus.taken_q}, 16'd0);
    check("pc_in_reset2", bus.PC_out, 16'hFF08);
    @(negedge clk); rst = 1'b0; #1;
    check("tq_before_edge", {15'd0, bus.taken_q}, 16'd0);
    @(posedge clk); #1;
    check("tq_after_release", {15'd0, bus.taken_q}, 16'd1);
    @(negedge clk);
    drive(3'b001, 9'd4, 3'b000, 16'hFF00);
    @(posedge clk); #1;
    check("tq_clear_by_data", {15'd0, bus.taken_q}, 16'd0);

    // Random sweep
    for (int k = 0; k < 300; k++) begin
      logic [2:0]  c, f;
      logic [8:0]  i;
      logic [15:0] pc;
      c  = 3'($urandom_range(0, 7));
      f  = 3'($urandom_range(0, 7));
      i  = 9'($urandom_range(0, 511));
      pc = 16'($urandom_range(0, 65535));
      drive(c, i, f, pc);
      check("rnd_pc", bus.PC_out, ref_pc(c, i, f, pc));
      check("rnd_taken", {15'd0, bus.taken}, {15'd0, ref_taken(c, f)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
